maxpool_reduce: RTL and testbench

Downstream datapath stage of the max-pool engine. The address generator issues feature-map read addresses and patch-boundary strobes. This block consumes the resulting read-data stream, one sample per patch element, and reduces each patch to its signed maximum, with optional ReLU. It writes one result per patch into the pooled-output memory through a 2-entry output queue with backpressure.

---
 rtl/maxpool_pkg.sv | 25 ++
 rtl/maxpool_outq.sv | 68 ++++++
 rtl/maxpool_reduce.sv | 153 +++++++++++++++
 tb/tb_maxpool_reduce.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool engine: FSM state encoding, default
// widths and a signed max helper that both the datapath and bench models use.
package maxpool_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 19;
    // Width the max helper works at; callers sign-extend narrower samples.
    localparam int MAX_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Signed maximum; on a tie the first operand is returned.
    function automatic logic signed [MAX_W-1:0] smax(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/maxpool_outq.sv
// 2-entry synchronous FIFO for pooled results.
// Entries shift toward slot 0 on pop so the head is always a plain register,
// which keeps the downstream address/data outputs glitch-free and stable
// while the consumer stalls.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_flush         empty the queue (wins over push/pop)
//   i_push, i_din   enqueue one entry
//   i_pop           dequeue the head (ignored when empty)
//   o_head          head entry
//   o_count         number of valid entries (0..2)
module maxpool_outq #(
    parameter int W = 35
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop   = i_pop && (r_count != 2'd0);
    // A full queue only takes a push when it is popping the same cycle.
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
    assign o_head  = r_e0;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0 <= i_din;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_din;
                    end
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_din;
                    else                 r_e1 <= i_din;
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/maxpool_reduce.sv
// Max-pool reduction stage: folds each patch of the incoming read-data stream
// to its signed maximum (optionally ReLU-clamped) and writes one result per
// patch to the pooled-output memory through a 2-entry queue.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_maxpool_enable          frame enable; low returns to IDLE and flushes
//   i_out_base                pooled-map base address, latched at frame start
//   i_sample_valid/_data/_last  sample stream, accepted when o_in_ready
//   i_frame_done              end of frame pulse
//   o_wr_en/i_wr_ready        output write handshake
//   o_wr_addr/o_wr_data       queue head
//   o_patch_count             results pushed this frame
//   o_pool_done               frame complete and drained
//   o_partial_err             sticky: frame ended mid-patch
module maxpool_reduce
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RELU   = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_maxpool_enable,
    input  logic [ADDR_W-1:0] i_out_base,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample_data,
    input  logic              i_sample_last,
    input  logic              i_frame_done,
    output logic              o_in_ready,
    output logic              o_wr_en,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W-1:0] o_patch_count,
    output logic              o_pool_done,
    output logic              o_partial_err
);

    localparam int EXT = MAX_W - DATA_W;
    localparam int QW  = ADDR_W + DATA_W;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_W-1:0]        r_acc;
    logic                     r_acc_valid;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_patch_count;
    logic                     r_partial_err;

    logic [1:0]               w_q_count;
    logic [QW-1:0]            w_q_head;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_flush;
    logic                     w_acc_wins;
    logic                     w_acc_valid_after;
    logic                     w_drained;
    logic signed [MAX_W-1:0]  w_acc_ext;
    logic signed [MAX_W-1:0]  w_smp_ext;
    logic [DATA_W-1:0]        w_cand;
    logic [DATA_W-1:0]        w_result;

    assign o_in_ready = (r_state == ST_ACCUM) && (w_q_count < 2'd2);
    assign w_accept   = i_sample_valid && o_in_ready;
    assign w_push     = w_accept && i_sample_last && i_maxpool_enable;
    assign o_wr_en    = (w_q_count != 2'd0);
    assign w_pop      = o_wr_en && i_wr_ready;
    // Queue is emptied whenever the frame is not running, and on the edge
    // that starts a new frame.
    assign w_flush    = (r_state == ST_IDLE) || !i_maxpool_enable;

    assign w_acc_ext  = {{EXT{r_acc[DATA_W-1]}}, r_acc};
    assign w_smp_ext  = {{EXT{i_sample_data[DATA_W-1]}}, i_sample_data};
    assign w_acc_wins = (smax(w_acc_ext, w_smp_ext) == w_acc_ext);
    assign w_cand     = (r_acc_valid && w_acc_wins) ? r_acc : i_sample_data;
    assign w_result   = ((RELU != 0) && w_cand[DATA_W-1]) ? '0 : w_cand;

    // Patch still open once this cycle's sample (if any) is folded in.
    assign w_acc_valid_after = w_accept ? !i_sample_last : r_acc_valid;
    // Queue empty after this edge; DRAIN never pushes.
    assign w_drained = (w_q_count == 2'd0) || ((w_q_count == 2'd1) && w_pop);

    assign o_wr_addr     = w_q_head[QW-1:DATA_W];
    assign o_wr_data     = w_q_head[DATA_W-1:0];
    assign o_patch_count = r_patch_count;
    assign o_pool_done   = (r_state == ST_DONE);
    assign o_partial_err = r_partial_err;

    maxpool_outq #(.W(QW)) u_outq (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   ({r_wr_ptr, w_result}),
        .i_pop   (w_pop),
        .o_head  (w_q_head),
        .o_count (w_q_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!i_maxpool_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_ACCUM;
                ST_ACCUM: if (i_frame_done) w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_drained)    w_state_nxt = ST_DONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_acc_valid   <= 1'b0;
            r_wr_ptr      <= '0;
            r_patch_count <= '0;
            r_partial_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!i_maxpool_enable) begin
                r_acc_valid <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                r_wr_ptr      <= i_out_base;
                r_patch_count <= '0;
                r_acc_valid   <= 1'b0;
                r_partial_err <= 1'b0;
            end else if (r_state == ST_ACCUM) begin
                if (w_accept) begin
                    if (i_sample_last) begin
                        r_wr_ptr      <= r_wr_ptr + 1'b1;
                        r_patch_count <= r_patch_count + 1'b1;
                        r_acc_valid   <= 1'b0;
                    end else begin
                        r_acc       <= w_cand;
                        r_acc_valid <= 1'b1;
                    end
                end
                // Frame end drops any open patch after this cycle's sample.
                if (i_frame_done) begin
                    if (w_acc_valid_after) r_partial_err <= 1'b1;
                    r_acc_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_reduce.sv
module tb_maxpool_reduce;
    localparam int DW = 16;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic sv = 1'b0;
    logic sl = 1'b0;
    logic fd = 1'b0;
    logic wr_ready = 1'b0;
    logic [AW-1:0] base = '0;
    logic [DW-1:0] sd = '0;

    logic          in_ready0, wr_en0, pool_done0, perr0;
    logic [AW-1:0] wr_addr0, pcount0;
    logic [DW-1:0] wr_data0;
    logic          in_ready1, wr_en1, pool_done1, perr1;
    logic [AW-1:0] wr_addr1, pcount1;
    logic [DW-1:0] wr_data1;

    maxpool_reduce #(.DATA_W(DW), .ADDR_W(AW), .RELU(0)) u0 (
        .i_clk(clk), .i_reset(reset), .i_maxpool_enable(en), .i_out_base(base),
        .i_sample_valid(sv), .i_sample_data(sd), .i_sample_last(sl), .i_frame_done(fd),
        .o_in_ready(in_ready0), .o_wr_en(wr_en0), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr0), .o_wr_data(wr_data0), .o_patch_count(pcount0),
        .o_pool_done(pool_done0), .o_partial_err(perr0));

    maxpool_reduce #(.DATA_W(DW), .ADDR_W(AW), .RELU(1)) u1 (
        .i_clk(clk), .i_reset(reset), .i_maxpool_enable(en), .i_out_base(base),
        .i_sample_valid(sv), .i_sample_data(sd), .i_sample_last(sl), .i_frame_done(fd),
        .o_in_ready(in_ready1), .o_wr_en(wr_en1), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr1), .o_wr_data(wr_data1), .o_patch_count(pcount1),
        .o_pool_done(pool_done1), .o_partial_err(perr1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit bp_rand = 1'b0;
    bit bp_val = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [AW+DW-1:0] got0_q[$], got1_q[$], exp0_q[$], exp1_q[$];

    always @(posedge clk) begin
        #1;
        wr_ready = bp_rand ? 1'($urandom_range(0, 1)) : bp_val;
    end

    // Record every write the memory side accepts.
    always @(negedge clk) begin
        if (wr_en0 && wr_ready) got0_q.push_back({wr_addr0, wr_data0});
        if (wr_en1 && wr_ready) got1_q.push_back({wr_addr1, wr_data1});
    end

    task automatic send(input int d, input bit last);
        int n = 0;
        sv = 1'b1; sd = DW'(d); sl = last;
        @(negedge clk);
        while (!in_ready0 && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++; $display("FAIL send_accept in_ready=%b required=1 after %0d cycles", in_ready0, n);
        end
        @(posedge clk); #1;
        sv = 1'b0; sl = 1'b0;
    endtask

    // Reference: one result per patch = signed max of its elements.
    task automatic send_patch(input int n, input int p[4]);
        int m;
        logic [DW-1:0] r1;
        m = p[0];
        for (int i = 0; i < n; i++) begin
            if (p[i] > m) m = p[i];
            send(p[i], i == n - 1);
        end
        r1 = (m < 0) ? '0 : DW'(m);
        exp0_q.push_back({m_addr, DW'(m)});
        exp1_q.push_back({m_addr, r1});
        m_addr = m_addr + 1'b1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b);
        en = 1'b0;
        @(posedge clk); #1;
        got0_q.delete(); got1_q.delete(); exp0_q.delete(); exp1_q.delete();
        base = b; m_addr = b; en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic end_frame();
        int n = 0;
        fd = 1'b1;
        @(posedge clk); #1;
        fd = 1'b0;
        @(negedge clk);
        while (!pool_done0 && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (pool_done0 !== 1'b1) begin
            errors++; $display("FAIL pool_done_timeout pool_done=%b required=1", pool_done0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b required=0", in_ready0); end
        checks++; if (wr_en0 !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b required=0", wr_en0); end
        checks++; if (wr_addr0 !== '0) begin errors++; $display("FAIL reset_wr_addr got=%h required=0", wr_addr0); end
        checks++; if (wr_data0 !== '0) begin errors++; $display("FAIL reset_wr_data got=%h required=0", wr_data0); end
        checks++; if (pcount0 !== '0) begin errors++; $display("FAIL reset_patch_count got=%0d required=0", pcount0); end
        checks++; if (pool_done0 !== 1'b0) begin errors++; $display("FAIL reset_pool_done got=%b required=0", pool_done0); end
        checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL reset_partial_err got=%b required=0", perr0); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bp_rand = 1'b0; bp_val = 1'b1;
        start_frame(19'd100);
        send_patch(4, '{3, -7, 12, 5});
        send_patch(4, '{-1, -4, -2, -9});
        end_frame();
        checks++; if (got0_q.size() != exp0_q.size()) begin errors++; $display("FAIL basic_nwrites got=%0d required=%0d", got0_q.size(), exp0_q.size()); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL basic_wr%0d got=%h required=%h", i, got0_q[i], exp0_q[i]); end
            checks++; if (got1_q[i] !== exp1_q[i]) begin errors++; $display("FAIL basic_relu_wr%0d got=%h required=%h", i, got1_q[i], exp1_q[i]); end
        end
        checks++; if (pcount0 !== 19'd2) begin errors++; $display("FAIL basic_patch_count got=%0d required=2", pcount0); end
        checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL basic_partial_err got=%b required=0", perr0); end
    endtask

    task automatic test_relu();
        start_frame(19'd150);
        send_patch(4, '{-5, -3, -8, -1});
        end_frame();
        checks++; if (got0_q.size() != 1 || got1_q.size() != 1) begin errors++; $display("FAIL relu_nwrites got=%0d/%0d required=1", got0_q.size(), got1_q.size()); end
        checks++; if (got0_q[0] !== exp0_q[0]) begin errors++; $display("FAIL relu_off_data got=%h required=%h", got0_q[0], exp0_q[0]); end
        checks++; if (got1_q[0] !== exp1_q[0]) begin errors++; $display("FAIL relu_on_data got=%h required=%h", got1_q[0], exp1_q[0]); end
    endtask

    task automatic test_back_to_back();
        start_frame(19'd1000);
        for (int k = 0; k < 5; k++) begin
            send_patch(1, '{k * 3 - 4, 0, 0, 0});
            checks++;
            if (wr_en0 !== 1'b1 || wr_data0 !== exp0_q[k][DW-1:0]) begin
                errors++; $display("FAIL b2b_latency%0d wr_en=%b data=%h required=1/%h", k, wr_en0, wr_data0, exp0_q[k][DW-1:0]);
            end
        end
        end_frame();
        checks++; if (got0_q.size() != exp0_q.size()) begin errors++; $display("FAIL b2b_nwrites got=%0d required=%0d", got0_q.size(), exp0_q.size()); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL b2b_wr%0d got=%h required=%h", i, got0_q[i], exp0_q[i]); end
            checks++; if (got1_q[i] !== exp1_q[i]) begin errors++; $display("FAIL b2b_relu_wr%0d got=%h required=%h", i, got1_q[i], exp1_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bp_val = 1'b0;
        start_frame(19'd200);
        send_patch(1, '{7, 0, 0, 0});
        send_patch(1, '{8, 0, 0, 0});
        sv = 1'b1; sd = DW'(9); sl = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready0 !== 1'b0 || wr_en0 !== 1'b1 || wr_addr0 !== 19'd200 || wr_data0 !== 16'd7) begin
                errors++; $display("FAIL bp_stall%0d in_ready=%b wr_en=%b addr=%h data=%h required=0/1/200/7", k, in_ready0, wr_en0, wr_addr0, wr_data0);
            end
        end
        bp_val = 1'b1;
        send_patch(1, '{9, 0, 0, 0});
        end_frame();
        checks++; if (got0_q.size() != 3) begin errors++; $display("FAIL bp_nwrites got=%0d required=3", got0_q.size()); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL bp_wr%0d got=%h required=%h", i, got0_q[i], exp0_q[i]); end
        end
    endtask

    task automatic test_partial();
        start_frame(19'd300);
        send_patch(2, '{1, 2, 0, 0});
        send(5, 1'b0);
        send(6, 1'b0);
        end_frame();
        checks++; if (got0_q.size() != 1) begin errors++; $display("FAIL partial_nwrites got=%0d required=1", got0_q.size()); end
        checks++; if (got0_q[0] !== exp0_q[0]) begin errors++; $display("FAIL partial_wr0 got=%h required=%h", got0_q[0], exp0_q[0]); end
        checks++; if (perr0 !== 1'b1) begin errors++; $display("FAIL partial_err got=%b required=1", perr0); end
        checks++; if (pcount0 !== 19'd1) begin errors++; $display("FAIL partial_patch_count got=%0d required=1", pcount0); end
    endtask

    task automatic test_wrap();
        start_frame(19'h7FFFF);
        send_patch(2, '{4, 9, 0, 0});
        send_patch(1, '{-3, 0, 0, 0});
        end_frame();
        checks++; if (got0_q.size() != 2) begin errors++; $display("FAIL wrap_nwrites got=%0d required=2", got0_q.size()); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL wrap_wr%0d got=%h required=%h", i, got0_q[i], exp0_q[i]); end
            checks++; if (got1_q[i] !== exp1_q[i]) begin errors++; $display("FAIL wrap_relu_wr%0d got=%h required=%h", i, got1_q[i], exp1_q[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        int p[4];
        bp_rand = 1'b1;
        start_frame(AW'($urandom()));
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < 4; j++) p[j] = int'(shortint'($urandom()));
            send_patch(n, p);
        end
        end_frame();
        bp_rand = 1'b0; bp_val = 1'b1;
        checks++; if (got0_q.size() != 8) begin errors++; $display("FAIL rand_nwrites got=%0d required=8", got0_q.size()); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL rand_wr%0d got=%h required=%h", i, got0_q[i], exp0_q[i]); end
            checks++; if (got1_q[i] !== exp1_q[i]) begin errors++; $display("FAIL rand_relu_wr%0d got=%h required=%h", i, got1_q[i], exp1_q[i]); end
        end
        checks++; if (pcount0 !== 19'd8) begin errors++; $display("FAIL rand_patch_count got=%0d required=8", pcount0); end
    endtask

    task automatic test_flush();
        // Enable dropped with a full queue.
        bp_val = 1'b0;
        start_frame(19'd400);
        send_patch(1, '{11, 0, 0, 0});
        send_patch(1, '{12, 0, 0, 0});
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_en0 !== 1'b0 || in_ready0 !== 1'b0 || pcount0 !== 19'd2) begin
            errors++; $display("FAIL flush_en wr_en=%b in_ready=%b patch_count=%0d required=0/0/2", wr_en0, in_ready0, pcount0);
        end
        bp_val = 1'b1;
        start_frame(19'd500);
        send_patch(1, '{13, 0, 0, 0});
        end_frame();
        checks++; if (got0_q.size() != 1 || got0_q[0] !== exp0_q[0]) begin errors++; $display("FAIL flush_en_after n=%0d got=%h required=%h", got0_q.size(), got0_q[0], exp0_q[0]); end
        // Reset with a full queue.
        bp_val = 1'b0;
        start_frame(19'd600);
        send_patch(1, '{21, 0, 0, 0});
        send_patch(1, '{22, 0, 0, 0});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_en0 !== 1'b0 || in_ready0 !== 1'b0 || pcount0 !== '0) begin
            errors++; $display("FAIL flush_reset wr_en=%b in_ready=%b patch_count=%0d required=0/0/0", wr_en0, in_ready0, pcount0);
        end
        reset = 1'b0;
        bp_val = 1'b1;
        start_frame(19'd700);
        send_patch(1, '{-3, 0, 0, 0});
        end_frame();
        checks++; if (got0_q.size() != 1 || got0_q[0] !== exp0_q[0]) begin errors++; $display("FAIL flush_reset_after n=%0d got=%h required=%h", got0_q.size(), got0_q[0], exp0_q[0]); end
        checks++; if (got1_q.size() != 1 || got1_q[0] !== exp1_q[0]) begin errors++; $display("FAIL flush_reset_relu n=%0d got=%h required=%h", got1_q.size(), got1_q[0], exp1_q[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_back_to_back();
        test_backpressure();
        test_partial();
        test_wrap();
        test_random();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
